// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - FP operator encoding shared by decode, sequencer and FPU
package ibex_pkg;

  // Encodings 9..15 are unassigned and sequenced with the miscellaneous timing.
  typedef enum logic [3:0] {
    FP_ALU_ADD    = 4'd0,
    FP_ALU_SUB    = 4'd1,
    FP_ALU_MUL    = 4'd2,
    FP_ALU_DIV    = 4'd3,
    FP_ALU_SQRT   = 4'd4,
    FP_ALU_MINMAX = 4'd5,
    FP_ALU_SGNJ   = 4'd6,
    FP_ALU_CLASS  = 4'd7,
    FP_ALU_CVT    = 4'd8
  } fp_alu_op_e;

endpackage

// File: rtl/fpu_seq_ctrl_if.sv
// rtl/fpu_seq_ctrl_if.sv - request, FPU and response signals of the FP sequencer
interface fpu_seq_ctrl_if;
  import ibex_pkg::*;

  logic        req_valid_i;
  logic        req_ready_o;
  fp_alu_op_e  req_op_i;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  logic [1:0]  req_mode_i;
  logic        flush_i;
  fp_alu_op_e  fpu_operator_o;
  logic [31:0] fpu_operand_a_o;
  logic [31:0] fpu_operand_b_o;
  logic [1:0]  fpu_mode_o;
  logic [31:0] fpu_result_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        busy_o;

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_mode_i, flush_i,
    output fpu_result_i, rsp_ready_i,
    input  req_ready_o, fpu_operator_o, fpu_operand_a_o, fpu_operand_b_o, fpu_mode_o,
    input  rsp_valid_o, rsp_result_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_mode_i, flush_i,
    input  fpu_result_i, rsp_ready_i,
    output req_ready_o, fpu_operator_o, fpu_operand_a_o, fpu_operand_b_o, fpu_mode_o,
    output rsp_valid_o, rsp_result_o, busy_o
  );

endinterface

// File: rtl/fpu_seq_ctrl.sv
// rtl/fpu_seq_ctrl.sv - FP issue/sequencing controller holding FPU inputs for a multicycle path
// Optional perf counters (perf_ops_o, perf_stall_o) under FPU_SEQ_PERF_CNT_EN.
module fpu_seq_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned ARITH_CYCLES = 2,
  parameter int unsigned MISC_CYCLES  = 1
) (
  input  logic         IO_CLK,
  input  logic         rst_ni,
  fpu_seq_ctrl_if.slave bus
`ifdef FPU_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]  perf_ops_o,
  output logic [31:0]  perf_stall_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  localparam logic [3:0] ARITH_LOAD = 4'(ARITH_CYCLES - 1);
  localparam logic [3:0] MISC_LOAD  = 4'(MISC_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept;
  logic       capture;
  logic       ready_raw;
  logic       req_ready;
  logic       rsp_valid;
  logic [3:0] cnt_load;

  always_comb begin
    cnt_load = MISC_LOAD;
    if (bus.req_op_i == FP_ALU_ADD || bus.req_op_i == FP_ALU_SUB || bus.req_op_i == FP_ALU_MUL) begin
      cnt_load = ARITH_LOAD;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    capture   = 1'b0;
    ready_raw = 1'b0;
    case (state_q)
      IDLE: begin
        ready_raw = !bus.flush_i;
        if (bus.req_valid_i && ready_raw) begin
          accept  = 1'b1;
          cnt_d   = cnt_load;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (bus.flush_i) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // A flush coinciding with the consumer handshake still cancels the response.
        if (bus.flush_i || bus.rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge IO_CLK or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FPU inputs only move on acceptance so the datapath sees them stable for the whole operation.
  always_ff @(posedge IO_CLK or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.fpu_operator_o  <= FP_ALU_ADD;
      bus.fpu_operand_a_o <= 32'd0;
      bus.fpu_operand_b_o <= 32'd0;
      bus.fpu_mode_o      <= 2'd0;
    end else if (accept) begin
      bus.fpu_operator_o  <= bus.req_op_i;
      bus.fpu_operand_a_o <= bus.req_a_i;
      bus.fpu_operand_b_o <= bus.req_b_i;
      bus.fpu_mode_o      <= bus.req_mode_i;
    end
  end

  always_ff @(posedge IO_CLK or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.rsp_result_o <= 32'd0;
    end else if (capture) begin
      bus.rsp_result_o <= bus.fpu_result_i;
    end
  end

  assign req_ready       = ready_raw && rst_ni;
  assign rsp_valid       = (state_q == RESP);
  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.busy_o      = (state_q != IDLE);

`ifdef FPU_SEQ_PERF_CNT_EN
  always_ff @(posedge IO_CLK or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_ops_o   <= 32'd0;
      perf_stall_o <= 32'd0;
    end else begin
      if (rsp_valid && bus.rsp_ready_i && !bus.flush_i) begin
        perf_ops_o <= perf_ops_o + 32'd1;
      end
      if (bus.req_valid_i && !req_ready) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// tb/tb_fpu_seq_ctrl.sv - randomized self-checking bench for fpu_seq_ctrl (FPU_SEQ_PERF_CNT_EN aware)
module tb_fpu_seq_ctrl;
  import ibex_pkg::*;

  localparam int ARITH = 2;
  localparam int MISC  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  fpu_seq_ctrl_if bus ();

`ifdef FPU_SEQ_PERF_CNT_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_stall;
`endif

  fpu_seq_ctrl #(
    .ARITH_CYCLES(ARITH),
    .MISC_CYCLES (MISC)
  ) dut (
    .IO_CLK(clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
`ifdef FPU_SEQ_PERF_CNT_EN
    ,
    .perf_ops_o  (perf_ops),
    .perf_stall_o(perf_stall)
`endif
  );

  // Stand-in FPU: any deterministic function of the presented inputs will do.
  function automatic logic [31:0] fake_fpu(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [1:0] mode);
    return (a + b) ^ {mode, 26'd0, op};
  endfunction

  function automatic int n_of(logic [3:0] op);
    return (op == FP_ALU_ADD || op == FP_ALU_SUB || op == FP_ALU_MUL) ? ARITH : MISC;
  endfunction

  assign bus.fpu_result_i = fake_fpu(bus.fpu_operator_o, bus.fpu_operand_a_o, bus.fpu_operand_b_o, bus.fpu_mode_o);

  // Called at a falling edge; returns at the falling edge of the first cycle after acceptance.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] mode, output bit ok);
    bit acc = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = fp_alu_op_e'(op);
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    bus.req_mode_i  = mode;
    for (int i = 0; i < 30 && !acc; i++) begin
      #1;
      acc = bus.req_ready_o;
      @(posedge clk);
      @(negedge clk);
    end
    bus.req_valid_i = 1'b0;
    ok = acc;
  endtask

  // Cycles since the acceptance cycle until rsp_valid_o is seen (bounded).
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = FP_ALU_ADD;
    bus.req_a_i     = 32'd0;
    bus.req_b_i     = 32'd0;
    bus.req_mode_i  = 2'd0;
    bus.flush_i     = 1'b0;
    bus.rsp_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready_in_reset: got %b want 0", bus.req_ready_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (bus.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o); end
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    vectors++; if (bus.rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid_o); end
    vectors++; if (bus.rsp_result_o !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h want 0", bus.rsp_result_o); end
    vectors++; if (bus.fpu_operator_o !== FP_ALU_ADD) begin miscompares++; $display("FAIL reset_operator: got %h want 0", bus.fpu_operator_o); end
    vectors++; if ({bus.fpu_operand_a_o, bus.fpu_operand_b_o, bus.fpu_mode_o} !== 66'd0) begin
      miscompares++; $display("FAIL reset_operands: got %h/%h/%h want 0", bus.fpu_operand_a_o, bus.fpu_operand_b_o, bus.fpu_mode_o);
    end
  endtask

  task automatic test_add();
    bit ok;
    int lat;
    logic [31:0] exp = fake_fpu(FP_ALU_ADD, 32'h3F800000, 32'h40000000, 2'd0);
    bus.rsp_ready_i = 1'b1;
    issue(FP_ALU_ADD, 32'h3F800000, 32'h40000000, 2'd0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL add_accept: got 0 want 1"); end
    wait_rsp(lat);
    vectors++; if (lat != ARITH + 1) begin miscompares++; $display("FAIL add_latency: got %0d want %0d", lat, ARITH + 1); end
    vectors++; if (bus.rsp_result_o !== exp) begin miscompares++; $display("FAIL add_result: got %h want %h", bus.rsp_result_o, exp); end
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL add_busy_after: got %b want 0", bus.busy_o); end
    vectors++; if (bus.rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL add_valid_after: got %b want 0", bus.rsp_valid_o); end
  endtask

  task automatic test_class();
    bit ok;
    int lat;
    logic [31:0] exp = fake_fpu(FP_ALU_CLASS, 32'h7F800000, 32'd0, 2'd0);
    bus.rsp_ready_i = 1'b0;
    issue(FP_ALU_CLASS, 32'h7F800000, 32'd0, 2'd0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL class_accept: got 0 want 1"); end
    vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL class_ready_exec: got %b want 0", bus.req_ready_o); end
    wait_rsp(lat);
    vectors++; if (lat != MISC + 1) begin miscompares++; $display("FAIL class_latency: got %0d want %0d", lat, MISC + 1); end
    vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL class_ready_resp: got %b want 0", bus.req_ready_o); end
    vectors++; if (bus.rsp_result_o !== exp) begin miscompares++; $display("FAIL class_result: got %h want %h", bus.rsp_result_o, exp); end
    handshake();
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL class_busy_after: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [31:0] a = $urandom;
    logic [31:0] b = $urandom;
    logic [31:0] exp = fake_fpu(FP_ALU_MUL, a, b, 2'd1);
    bus.rsp_ready_i = 1'b0;
    issue(FP_ALU_MUL, a, b, 2'd1, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_accept: got 0 want 1"); end
    wait_rsp(lat);
    vectors++; if (lat != ARITH + 1) begin miscompares++; $display("FAIL bp_latency: got %0d want %0d", lat, ARITH + 1); end
    // A competing request stays pending the whole time and must not disturb the held operands.
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = FP_ALU_DIV;
    bus.req_a_i     = ~a;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_result_o !== exp) begin
        miscompares++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", i, bus.rsp_valid_o, bus.rsp_result_o, exp);
      end
      vectors++; if (bus.fpu_operand_a_o !== a || bus.req_ready_o !== 1'b0) begin
        miscompares++; $display("FAIL bp_operand[%0d]: got %h/%b want %h/0", i, bus.fpu_operand_a_o, bus.req_ready_o, a);
      end
    end
    bus.req_valid_i = 1'b0;
    handshake();
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL bp_busy_after: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_flush();
    bit ok;
    int lat;
    logic [31:0] a = $urandom;
    logic [31:0] b = $urandom;
    bit seen = 1'b0;
    bus.rsp_ready_i = 1'b1;
    issue(FP_ALU_SUB, $urandom, $urandom, 2'd2, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL flush_accept: got 0 want 1"); end
    bus.flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b0;
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL flush_idle: got busy %b want 0", bus.busy_o); end
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid_o) seen = 1'b1;
      @(negedge clk);
    end
    vectors++; if (seen) begin miscompares++; $display("FAIL flush_no_rsp: got rsp_valid 1 want 0"); end
    issue(FP_ALU_ADD, a, b, 2'd0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL flush_next_accept: got 0 want 1"); end
    wait_rsp(lat);
    vectors++; if (lat != ARITH + 1 || bus.rsp_result_o !== fake_fpu(FP_ALU_ADD, a, b, 2'd0)) begin
      miscompares++; $display("FAIL flush_next_rsp: got lat %0d res %h want %0d/%h", lat, bus.rsp_result_o, ARITH + 1, fake_fpu(FP_ALU_ADD, a, b, 2'd0));
    end
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    bit seen = 1'b0;
    issue(FP_ALU_ADD, 32'h12345678, 32'h0F0F0F0F, 2'd3, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL arst_accept: got 0 want 1"); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if ({bus.busy_o, bus.rsp_valid_o, bus.req_ready_o} !== 3'b000) begin
      miscompares++; $display("FAIL arst_ctrl: got busy/valid/ready %b%b%b want 000", bus.busy_o, bus.rsp_valid_o, bus.req_ready_o);
    end
    vectors++; if ({bus.fpu_operator_o, bus.fpu_operand_a_o, bus.fpu_operand_b_o, bus.fpu_mode_o, bus.rsp_result_o} !== 102'd0) begin
      miscompares++; $display("FAIL arst_data: got op %h a %h b %h m %h r %h want 0", bus.fpu_operator_o, bus.fpu_operand_a_o, bus.fpu_operand_b_o, bus.fpu_mode_o, bus.rsp_result_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    vectors++; if (bus.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL arst_ready_after: got %b want 1", bus.req_ready_o); end
    for (int i = 0; i < 5; i++) begin
      if (bus.rsp_valid_o || bus.busy_o) seen = 1'b1;
      @(negedge clk);
    end
    vectors++; if (seen) begin miscompares++; $display("FAIL arst_stale_rsp: got activity 1 want 0"); end
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit ok;
      int lat;
      logic [3:0]  op   = 4'($urandom_range(0, 15));
      logic [31:0] a    = $urandom;
      logic [31:0] b    = $urandom;
      logic [1:0]  mode = 2'($urandom_range(0, 3));
      int          hold = $urandom_range(0, 3);
      logic [31:0] exp  = fake_fpu(op, a, b, mode);
      bus.rsp_ready_i = 1'b0;
      issue(op, a, b, mode, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rnd_accept[%0d]: got 0 want 1", n); end
      wait_rsp(lat);
      vectors++; if (lat != n_of(op) + 1) begin miscompares++; $display("FAIL rnd_latency[%0d] op %0d: got %0d want %0d", n, op, lat, n_of(op) + 1); end
      vectors++; if (bus.rsp_result_o !== exp) begin miscompares++; $display("FAIL rnd_result[%0d]: got %h want %h", n, bus.rsp_result_o, exp); end
      vectors++; if ({4'(bus.fpu_operator_o), bus.fpu_operand_a_o, bus.fpu_operand_b_o, bus.fpu_mode_o} !== {op, a, b, mode}) begin
        miscompares++; $display("FAIL rnd_fpu_in[%0d]: got %h %h %h %h want %h %h %h %h", n, bus.fpu_operator_o, bus.fpu_operand_a_o, bus.fpu_operand_b_o, bus.fpu_mode_o, op, a, b, mode);
      end
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        vectors++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_result_o !== exp) begin
          miscompares++; $display("FAIL rnd_hold[%0d]: got %b/%h want 1/%h", n, bus.rsp_valid_o, bus.rsp_result_o, exp);
        end
      end
      handshake();
      vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL rnd_busy_after[%0d]: got %b want 0", n, bus.busy_o); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [3:0]  op, last_op;
    logic [31:0] a, b;
    int          issued = 0;
    int          last_acc = 0;
    bit          acc;
    op = 4'($urandom_range(0, 8)); a = $urandom; b = $urandom;
    bus.req_op_i = fp_alu_op_e'(op); bus.req_a_i = a; bus.req_b_i = b; bus.req_mode_i = 2'd0;
    bus.req_valid_i = 1'b1;
    bus.rsp_ready_i = 1'b1;
    for (int cyc = 0; cyc < 200 && (issued < 6 || exp_q.size() > 0); cyc++) begin
      #1;
      acc = 1'b0;
      if (bus.rsp_valid_o) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL b2b_spurious_rsp: got %h want none", bus.rsp_result_o);
        end else if (bus.rsp_result_o !== exp_q[0]) begin
          miscompares++; $display("FAIL b2b_result: got %h want %h", bus.rsp_result_o, exp_q[0]);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (bus.req_valid_i && bus.req_ready_o) begin
        if (issued > 0) begin
          vectors++; if (cyc - last_acc != n_of(last_op) + 2) begin
            miscompares++; $display("FAIL b2b_interval: got %0d want %0d", cyc - last_acc, n_of(last_op) + 2);
          end
        end
        exp_q.push_back(fake_fpu(op, a, b, 2'd0));
        last_acc = cyc;
        last_op  = op;
        issued++;
        acc = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        if (issued < 6) begin
          op = 4'($urandom_range(0, 8)); a = $urandom; b = $urandom;
          bus.req_op_i = fp_alu_op_e'(op); bus.req_a_i = a; bus.req_b_i = b;
        end else begin
          bus.req_valid_i = 1'b0;
        end
      end
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    vectors++; if (issued != 6 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL b2b_complete: got issued %0d pending %0d want 6/0", issued, exp_q.size());
    end
  endtask

`ifdef FPU_SEQ_PERF_CNT_EN
  task automatic test_perf();
    bit ok;
    int lat;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++; if (perf_ops !== 32'd0 || perf_stall !== 32'd0) begin
      miscompares++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_ops, perf_stall);
    end
    bus.flush_i = 1'b1;
    bus.req_valid_i = 1'b1;
    repeat (4) @(negedge clk);
    bus.flush_i = 1'b0;
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(4'($urandom_range(0, 8)), $urandom, $urandom, 2'd0, ok);
      wait_rsp(lat);
      handshake();
    end
    issue(FP_ALU_SUB, $urandom, $urandom, 2'd0, ok);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    @(negedge clk);
    vectors++; if (perf_ops !== 32'd3) begin miscompares++; $display("FAIL perf_ops: got %0d want 3", perf_ops); end
    vectors++; if (perf_stall !== 32'd4) begin miscompares++; $display("FAIL perf_stall: got %0d want 4", perf_stall); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_class();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    test_back_to_back();
`ifdef FPU_SEQ_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_seq_ctrl.md
Name: fpu_seq_ctrl

Overview:
- Issue/sequencing controller between the core's FP decode stage and the combinational 32-bit FPU datapath.
- Accepts one FP operation per valid/ready handshake and registers the operator, operands and mode.
- Holds those registers stable on the FPU inputs for a configurable number of cycles, so the FPU can be constrained as a multicycle path.
- Captures the FPU result and returns it through a valid/ready response channel. Supports pipeline flush.

Parameters:
- ARITH_CYCLES, 2, FPU evaluation cycles for FP_ALU_ADD, FP_ALU_SUB and FP_ALU_MUL; legal range 1..15.
- MISC_CYCLES, 1, FPU evaluation cycles for all other operators; legal range 1..15.

Ports:
- IO_CLK  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted this cycle when high together with req_valid_i.
- req_op_i  in  ibex_pkg::fp_alu_op_e  requested operator.
- req_a_i  in  32  operand A.
- req_b_i  in  32  operand B.
- req_mode_i  in  2  operator mode bits.
- flush_i  in  1  abort any in-flight operation.
- fpu_operator_o  out  ibex_pkg::fp_alu_op_e  registered operator to the FPU.
- fpu_operand_a_o  out  32  registered operand A to the FPU.
- fpu_operand_b_o  out  32  registered operand B to the FPU.
- fpu_mode_o  out  2  registered mode to the FPU.
- fpu_result_i  in  32  FPU combinational result.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_result_o  out  32  registered result.
- busy_o  out  1  high whenever the controller is not in IDLE.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state = IDLE; cycle counter = 0.
  - All fpu_*_o = 0; fpu_operator_o = FP_ALU_ADD, the enum's zero encoding.
  - rsp_result_o = 0, rsp_valid_o = 0, busy_o = 0.
  - req_ready_o is 0 while rst_ni is low.
- Reset deasserted mid-operation: the operation is lost; no response is produced.
- State machine states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready_o = !flush_i.
  - On req_valid_i & req_ready_o: capture op, a, b and mode into the fpu_*_o registers; load counter with (ARITH_CYCLES-1) for ADD/SUB/MUL, otherwise (MISC_CYCLES-1); next state EXEC.
  - Unknown or default operator encodings use MISC_CYCLES.
- EXEC:
  - req_ready_o = 0.
  - If counter != 0, decrement it.
  - If counter == 0, capture fpu_result_i into rsp_result_o; next state RESP.
- RESP:
  - rsp_valid_o = 1.
  - rsp_result_o and all fpu_*_o hold stable until the handshake.
  - On rsp_ready_i, next state IDLE; no new request is accepted in that same cycle.
- Latency: request accepted at edge T gives rsp_valid_o high from cycle T+1+N, where N is the selected cycle count.
  - Throughput: one operation per N+2 cycles when rsp_ready_i is held high.
- fpu_*_o change only at request acceptance. They never change during EXEC or RESP.
- flush_i:
  - In EXEC or RESP: next state IDLE; rsp_valid_o = 0 from the next cycle; no response for the flushed operation.
  - Flush in RESP coincident with rsp_ready_i: the flush wins; the consumer must treat the response as cancelled.
  - Flush in IDLE coincident with req_valid_i: no acceptance, because req_ready_o = 0.
- Counter width is 4 bits; it never wraps below 0.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: FPU_SEQ_PERF_CNT_EN.
- Defined: adds perf_ops_o (out, 32) and perf_stall_o (out, 32), both reset to 0.
  - perf_ops_o increments on each rsp_valid_o & rsp_ready_i & !flush_i.
  - perf_stall_o increments each cycle req_valid_i is high and req_ready_o is low.
  - Both counters wrap at 2^32-1 to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then ADD with a=0x3F800000, b=0x40000000 at defaults, rsp_ready_i=1 -> rsp_valid_o high exactly 3 cycles after acceptance; rsp_result_o equals the FPU output for those operands; busy_o low the cycle after the handshake.
- CLASS with a=0x7F800000, MISC_CYCLES=1 -> response 2 cycles after acceptance; req_ready_o low during EXEC and RESP.
- MUL accepted, then rsp_ready_i held low for 5 cycles -> rsp_valid_o and rsp_result_o stable for all 5 cycles; fpu_operand_a_o unchanged; req_ready_o = 0 throughout.
- flush_i pulsed in the first EXEC cycle of SUB -> no rsp_valid_o ever asserted for it; state IDLE next cycle; a following request is accepted normally.
- rst_ni dropped asynchronously mid-EXEC -> all outputs 0 immediately; after release, req_ready_o=1 and no stale response.
- With FPU_SEQ_PERF_CNT_EN: 3 completed ops and 1 flushed op, requester stalled 4 cycles -> perf_ops_o=3, perf_stall_o=4.
